// File: rtl/flop_pipe_pkg.sv
// flop_pipe_pkg: shared widths and helpers for the flop_pipe pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flop_pipe_pkg;

  // Width of the stall counter exposed when statistics are built in.
  localparam int STALL_CNT_W = 32;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_pipe_stage.sv
// flop_pipe_stage: one valid+data slot of the flop_pipe pipeline.
// Latency: 1 cycle from upstream valid/data to this slot's registers.
// Backpressure: holds its contents whenever adv is low; clr drops valid only.
//
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   clr          : synchronous clear of the valid bit (data kept)
//   adv          : slot takes the upstream valid (and data if that valid is 1)
//   in_v, in_d   : upstream valid/data
//   v, d         : registered valid/data of this slot
module flop_pipe_stage #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             adv,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= 1'b0;
      d <= SEED;
    end else if (clr) begin
      v <= 1'b0;
    end else if (adv) begin
      v <= in_v;
      // A bubble moving in leaves the old data in place.
      if (in_v) begin
        d <= in_d;
      end
    end
  end

endmodule

// File: rtl/flop_pipe.sv
// flop_pipe: DEPTH-stage valid/ready pipeline register with bubble collapsing.
// Latency: DEPTH cycles from input handshake to out_valid; 1 item/cycle throughput.
// Backpressure: in_ready is combinational from out_ready through the stage chain.
//
// Ports:
//   clk, reset_n           : clock and asynchronous active-low reset
//   en                     : global enable, 0 freezes all stages
//   flush                  : synchronous clear of all valid bits (wins over en)
//   in_valid/in_data/in_ready    : upstream handshake
//   out_valid/out_data/out_ready : downstream handshake
//   occupancy              : number of valid stages
//   stats_clr, stall_cnt   : only when FLOP_PIPE_STATS_EN is defined; counts
//                            cycles the output stage is held by out_ready=0
module flop_pipe
  import flop_pipe_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [occ_w(DEPTH)-1:0]   occupancy
`ifdef FLOP_PIPE_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [STALL_CNT_W-1:0]    stall_cnt
`endif
);

  localparam int OCC_W = occ_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("flop_pipe: DEPTH must be at least 1");
  end

  logic             run;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];

  assign run = en & ~flush;

  // A stage can move when it is empty or the stage ahead moves too,
  // which is what lets bubbles collapse while the output is stalled.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = ~v[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = ~v[i] | adv[i+1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign src_v[i] = in_valid;
      assign src_d[i] = in_data;
    end else begin : g_body
      assign src_v[i] = v[i-1];
      assign src_d[i] = d[i-1];
    end

    flop_pipe_stage #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush),
      .adv     (run & adv[i]),
      .in_v    (src_v[i]),
      .in_d    (src_d[i]),
      .v       (v[i]),
      .d       (d[i])
    );
  end

  // reset_n gates in_ready so nothing looks acceptable while in reset.
  assign in_ready  = reset_n & run & adv[0];
  assign out_valid = run & v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(v[i]);
    end
  end

`ifdef FLOP_PIPE_STATS_EN
  logic stall;

  assign stall = v[DEPTH-1] & run & ~out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stats_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_flop_pipe.sv
// tb_flop_pipe: randomized and directed checks of flop_pipe (WIDTH=8, DEPTH=3,
// SEED=8'hA5) against a slot model plus an in-order scoreboard.
// Stall counter checks are included when FLOP_PIPE_STATS_EN is defined.
module tb_flop_pipe;

  localparam int         W = 8;
  localparam int         D = 3;
  localparam logic [7:0] S = 8'hA5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;
  logic         stats_clr;
`ifdef FLOP_PIPE_STATS_EN
  logic [31:0]  stall_cnt;
`endif

  flop_pipe #(
    .WIDTH (W),
    .DEPTH (D),
    .SEED  (S)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef FLOP_PIPE_STATS_EN
    ,
    .stats_clr (stats_clr),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference state: which slots hold an item, what each data register holds,
  // items accepted but not yet delivered, and the stall count.
  bit          mv [D];
  logic [7:0]  md [D];
  logic [7:0]  sb [$];
  logic [31:0] mstall;

  int n_vec;
  int n_err;
  int cyc;
  int first_acc;
  int first_out;
  int n_in;
  int n_out;
  int occ_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      mv[i] = 1'b0;
      md[i] = S;
    end
    sb.delete();
    mstall = '0;
  endtask

  // Called just after a falling edge with inputs already driven: check the
  // outputs against the model, then advance the model across the rising edge.
  task automatic cycle();
    bit       a [D];
    bit       nxt;
    bit       run;
    bit       e_in_rdy;
    bit       e_out_vld;
    bit       sv;
    logic [7:0] sd;
    int       occ;
    logic [7:0] head;
    #1;
    run = en && !flush;
    nxt = out_ready;
    for (int i = D - 1; i >= 0; i--) begin
      a[i] = !mv[i] || nxt;
      nxt  = a[i];
    end
    occ = 0;
    for (int i = 0; i < D; i++) occ += int'(mv[i]);
    e_in_rdy  = run && a[0];
    e_out_vld = run && mv[D-1];

    chk("in_ready",  in_ready,  e_in_rdy);
    chk("out_valid", out_valid, e_out_vld);
    chk("out_data",  out_data,  md[D-1]);
    chk("occupancy", occupancy, occ);
`ifdef FLOP_PIPE_STATS_EN
    chk("stall_cnt", stall_cnt, mstall);
`endif

    if (e_out_vld && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL order: output %0h delivered with nothing outstanding", out_data);
      end else begin
        head = sb.pop_front();
        chk("order", out_data, head);
      end
    end
    if (in_valid && e_in_rdy) begin
      sb.push_back(in_data);
      n_in++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (first_acc >= 0 && first_out < 0 && out_valid === 1'b1) first_out = cyc;

    if (stats_clr) mstall = '0;
    else if (mv[D-1] && run && !out_ready && mstall != 32'hFFFF_FFFF) mstall++;

    if (flush) begin
      for (int i = 0; i < D; i++) mv[i] = 1'b0;
      sb.delete();
    end else if (run) begin
      for (int i = D - 1; i >= 0; i--) begin
        if (a[i]) begin
          sv = (i == 0) ? in_valid : mv[i-1];
          sd = (i == 0) ? in_data  : md[i-1];
          mv[i] = sv;
          if (sv) md[i] = sd;
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input bit iv, input logic [7:0] id, input bit ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2; i++) drive(1'b0, 8'h44, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    first_acc = -1; first_out = -1; n_in = 0; n_out = 0;
    reset_n = 1'b0; en = 1'b1; flush = 1'b0; stats_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  S);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready",  in_ready,  1'b0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    // Stream 0x01..0x0A with the sink always ready.
    for (int i = 1; i <= 10; i++) drive(1'b1, 8'(i), 1'b1);
    drain();
    chk("stream_latency", first_out - first_acc, D);
    chk("stream_count", n_out, 10);
    chk("stream_left", sb.size(), 0);

    // Fill with the sink stalled, then release it with a 4th item waiting.
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0);
    in_valid = 1'b1; in_data = 8'h04; out_ready = 1'b0;
    #1;
    chk("full_occupancy", occupancy, D);
    chk("full_in_ready",  in_ready,  1'b0);
    out_ready = 1'b1;
    #1;
    chk("full_release_in_ready", in_ready, 1'b1);
    chk("full_release_head", out_data, 8'h01);
    cycle();
    drain();

    // Bubbles behind a stalled output collapse; bubble data is never captured.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b0, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b0, 8'h44, 1'b0);
    drive(1'b0, 8'h55, 1'b0);
    chk("bubble_occupancy", occupancy, 2);
    chk("bubble_head", out_data, 8'h11);
    drain();
    chk("bubble_stale_data", out_data, 8'h33);

    // Flush with a live input: pipe empties and the input is dropped.
    drive(1'b1, 8'h61, 1'b0);
    drive(1'b1, 8'h62, 1'b0);
    flush = 1'b1;
    drive(1'b1, 8'h77, 1'b1);
    flush = 1'b0;
    #1;
    chk("flush_occupancy", occupancy, 0);
    chk("flush_out_valid", out_valid, 1'b0);
    drive(1'b0, 8'h00, 1'b1);

    // Enable dropped for 5 cycles mid-stream.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h80 + 8'(i), (i % 2) == 0);
    occ_hold = int'(occupancy);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h90 + 8'(i), 1'b1);
      chk("en_off_occupancy", occupancy, occ_hold);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b1);
    drain();
    chk("en_resume_left", sb.size(), 0);

`ifdef FLOP_PIPE_STATS_EN
    // Stall counter: fill, clear, then hold the full pipe 7 cycles.
    for (int i = 0; i < D; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0);
    stats_clr = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    stats_clr = 1'b0;
    for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b0);
    chk("stall_hold7", stall_cnt, 7);
    stats_clr = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    stats_clr = 1'b0;
    chk("stall_clr", stall_cnt, 0);
    drain();
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en        = ($urandom % 8) != 0;
      flush     = ($urandom % 32) == 0;
      stats_clr = ($urandom % 64) == 0;
      drive(1'($urandom), 8'($urandom), ($urandom % 4) != 0);
    end
    en = 1'b1; flush = 1'b0; stats_clr = 1'b0;
    drain();
    chk("random_left", sb.size(), 0);

    // Asynchronous reset in the middle of a stalled stream.
    for (int i = 0; i < D; i++) drive(1'b1, 8'hE0 + 8'(i), 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data",  out_data,  S);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_in_ready",  in_ready,  1'b0);
`ifdef FLOP_PIPE_STATS_EN
    chk("arst_stall_cnt", stall_cnt, 0);
`endif
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i) + 8'hF0, 1'b1);
    drain();
    chk("arst_resume_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
